// File: rtl/dispatch_scheduler_pkg.sv
// Shared types for the kernel dispatch scheduler: config struct, counters, FSM encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dispatch_scheduler_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        data_t num_blocks;
        data_t kernel_id;
    } kernel_config_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } dispatch_state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_RESET = 2'd1,
        C_RUN   = 2'd2
    } core_state_t;

endpackage

// File: rtl/dispatch_scheduler_arb.sv
// Picks one requesting core per cycle, round-robin from the last grant or fixed lowest-index.
// Latency: grant is combinational from req; pointer moves on the clock edge after a grant.
// Backpressure: none; an empty request vector simply yields no grant.
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int RR_ARB    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] req,
    output logic [NUM_CORES-1:0] grant
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan starting just past the last winner (or from index 0) and take the first requester
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (RR_ARB != 0) begin
                idx = PTR_W'((int'(ptr) + 1 + i) % NUM_CORES);
            end else begin
                idx = PTR_W'(i);
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Remember the last winner; reset value makes core 0 the first round-robin candidate
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PTR_W'(NUM_CORES - 1);
        end else if (found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// Splits a kernel launch into blocks and hands them to idle cores, one dispatch per cycle.
// Latency: handshake -> first core_reset 2 cycles, core_start one cycle later; done/aborted are registered pulses.
// Backpressure: launch_ready only in IDLE with a non-empty mask; per-core done is a level sampled in C_RUN.
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int RR_ARB    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  kernel_config_t       kernel_config,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic                 abort,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] core_start,
    output logic [NUM_CORES-1:0] core_reset,
    output data_t                core_block_id [NUM_CORES],
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output data_t                blocks_done
);

    dispatch_state_t      state;
    core_state_t          core_state [NUM_CORES];
    data_t                num_blocks;
    data_t                blocks_dispatched;
    data_t                blocks_done_next;
    logic [NUM_CORES-1:0] mask;
    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] grant;
    logic [NUM_CORES-1:0] finishing;
    logic                 handshake;
    logic                 abort_hit;
    logic                 unused_cfg;

    // Only the block count matters to dispatch; the rest of the config is carried elsewhere
    assign unused_cfg = ^kernel_config.kernel_id;

    assign launch_ready = (state == IDLE) && (core_mask != '0);
    assign handshake    = launch_valid && launch_ready;
    assign abort_hit    = abort && (state != IDLE);

    // Eligible cores: idle, in the latched mask, with blocks still left to hand out
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i] = (state == RUN) && !abort && (core_state[i] == C_IDLE) && mask[i] &&
                     (blocks_dispatched < num_blocks);
        end
    end

    // Count the cores retiring a block this cycle; several can finish together
    always_comb begin
        finishing        = '0;
        blocks_done_next = blocks_done;
        for (int i = 0; i < NUM_CORES; i++) begin
            finishing[i]     = (core_state[i] == C_RUN) && core_done[i];
            blocks_done_next = blocks_done_next + data_t'(finishing[i]);
        end
    end

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .RR_ARB    (RR_ARB)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    // Kernel-level FSM: latch the launch, track counts, finish or abort
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            num_blocks        <= '0;
            mask              <= '0;
            blocks_dispatched <= '0;
            blocks_done       <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            aborted           <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        num_blocks        <= kernel_config.num_blocks;
                        mask              <= core_mask;
                        blocks_dispatched <= '0;
                        blocks_done       <= '0;
                        busy              <= 1'b1;
                        if (kernel_config.num_blocks == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
                        if (grant != '0) begin
                            blocks_dispatched <= blocks_dispatched + data_t'(1);
                        end
                        blocks_done <= blocks_done_next;
                        if (blocks_done_next == num_blocks) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    aborted <= abort;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-core FSMs: one-cycle reset pulse, then run until the core reports its block done
    always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
            core_start <= '0;
            core_reset <= '1;
            for (int i = 0; i < NUM_CORES; i++) begin
                core_state[i] <= C_IDLE;
            end
            if (reset) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    core_block_id[i] <= '0;
                end
            end
        end else begin
            core_reset <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                case (core_state[i])
                    C_IDLE: begin
                        if (grant[i]) begin
                            core_state[i]    <= C_RESET;
                            core_reset[i]    <= 1'b1;
                            core_block_id[i] <= blocks_dispatched;
                        end
                    end
                    C_RESET: begin
                        core_state[i] <= C_RUN;
                        core_start[i] <= 1'b1;
                    end
                    C_RUN: begin
                        if (core_done[i]) begin
                            core_state[i] <= C_IDLE;
                            core_start[i] <= 1'b0;
                        end
                    end
                    default: begin
                        core_state[i] <= C_IDLE;
                        core_start[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench: a round-robin and a fixed-priority scheduler share launch stimulus.
// Latency: each core answers core_done in its fifth cycle with core_start high.
// Backpressure: launches are only offered while both schedulers are idle.
module tb_dispatch_scheduler;
    import dispatch_scheduler_pkg::*;

    localparam int OFF1 [8] = '{3, 4, 5, 6, 10, 11, 12, 13};

    logic           clk = 1'b0;
    logic           reset;
    logic           launch_valid;
    logic           abort;
    logic [3:0]     mask;
    kernel_config_t cfg;

    logic [3:0] c_start [2];
    logic [3:0] c_reset [2];
    logic [3:0] c_done  [2];
    logic       rdy     [2];
    logic       bsy     [2];
    logic       dn      [2];
    logic       abd     [2];
    data_t      bdone   [2];
    data_t      bid0    [4];
    data_t      bid1    [4];

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         cnt [2][4];
    logic [3:0] prev_start [2] = '{4'h0, 4'h0};
    int         lg0 [$];
    int         lg1 [$];
    int         done_cnt [2] = '{0, 0};
    int         done_at  [2] = '{0, 0};
    int         ab_cnt   [2] = '{0, 0};
    int         act_cnt  [2] = '{0, 0};

    always #5 clk = ~clk;

    dispatch_scheduler #(.NUM_CORES(4), .RR_ARB(1)) dut_rr (
        .clk           (clk),
        .reset         (reset),
        .launch_valid  (launch_valid),
        .launch_ready  (rdy[0]),
        .kernel_config (cfg),
        .core_mask     (mask),
        .abort         (abort),
        .core_done     (c_done[0]),
        .core_start    (c_start[0]),
        .core_reset    (c_reset[0]),
        .core_block_id (bid0),
        .busy          (bsy[0]),
        .done          (dn[0]),
        .aborted       (abd[0]),
        .blocks_done   (bdone[0])
    );

    dispatch_scheduler #(.NUM_CORES(4), .RR_ARB(0)) dut_fp (
        .clk           (clk),
        .reset         (reset),
        .launch_valid  (launch_valid),
        .launch_ready  (rdy[1]),
        .kernel_config (cfg),
        .core_mask     (mask),
        .abort         (abort),
        .core_done     (c_done[1]),
        .core_start    (c_start[1]),
        .core_reset    (c_reset[1]),
        .core_block_id (bid1),
        .busy          (bsy[1]),
        .done          (dn[1]),
        .aborted       (abd[1]),
        .blocks_done   (bdone[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: count cycles with core_start high
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                cnt[d][i] <= c_start[d][i] ? cnt[d][i] + 1 : 0;
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            c_done[d] = '0;
            for (int i = 0; i < 4; i++)
                c_done[d][i] = c_start[d][i] && (cnt[d][i] == 4);
        end
    end

    // Monitor: log each core_start rise as cycle/core/block id, count pulses and activity
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (c_start[d][i] && !prev_start[d][i]) begin
                    if (d == 0) lg0.push_back(cyc * 256 + i * 16 + int'(bid0[i]));
                    else        lg1.push_back(cyc * 256 + i * 16 + int'(bid1[i]));
                end
            end
            prev_start[d] <= c_start[d];
            if (dn[d]) begin
                done_cnt[d] <= done_cnt[d] + 1;
                done_at[d]  <= cyc;
            end
            if (abd[d]) ab_cnt[d] <= ab_cnt[d] + 1;
            if ((|c_start[d]) || (|c_reset[d])) act_cnt[d] <= act_cnt[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ent(input int d, input int k);
        if (d == 0) return (k < lg0.size()) ? lg0[k] : -1;
        return (k < lg1.size()) ? lg1[k] : -1;
    endfunction

    task automatic check_ent(input string tag, input int d, input int k, input int c0,
                             input int off, input int core, input int id);
        check(tag, 64'(ent(d, k)), 64'((c0 + off) * 256 + core * 16 + id));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [3:0] m, input int nb, output int c0);
        c0              = cyc;
        mask            = m;
        cfg.num_blocks  = data_t'(nb);
        cfg.kernel_id   = data_t'(nb + 16'h100);
        launch_valid    = 1'b1;
        step(1);
        launch_valid    = 1'b0;
    endtask

    initial begin
        int c0, b0, b1, sd, sa, sact;
        reset        = 1'b1;
        launch_valid = 1'b0;
        abort        = 1'b0;
        mask         = 4'h0;
        cfg          = '0;
        step(3);

        // Reset values
        check("rst_core_reset", 64'(c_reset[0]), 64'h0f);
        check("rst_core_start", 64'(c_start[0]), 64'h0);
        check("rst_busy_done_aborted", {61'd0, bsy[0], dn[0], abd[0]}, 64'h0);
        check("rst_blocks_done", 64'(bdone[0]), 64'h0);
        check("rst_block_ids", {bid0[3], bid0[2], bid0[1], bid0[0]}, 64'h0);
        reset = 1'b0;
        step(1);
        check("rst_release_core_reset", 64'(c_reset[0]), 64'h0);

        // Full mask, 8 blocks: four-way fan-out then refill as cores finish
        b0 = lg0.size();
        sd = done_cnt[0];
        launch(4'hf, 8, c0);
        check("t1_busy", 64'(bsy[0]), 64'h1);
        step(17);
        check("t1_done_pulse", 64'(dn[0]), 64'h1);
        check("t1_blocks_done", 64'(bdone[0]), 64'd8);
        check("t1_busy_finish", 64'(bsy[0]), 64'h1);
        step(1);
        check("t1_done_low", {62'd0, dn[0], bsy[0]}, 64'h0);
        check("t1_done_count", 64'(done_cnt[0] - sd), 64'd1);
        check("t1_done_cycle", 64'(done_at[0]), 64'(c0 + 18));
        check("t1_log_size", 64'(lg0.size() - b0), 64'd8);
        for (int k = 0; k < 8; k++) check_ent("t1_log", 0, b0 + k, c0, OFF1[k], k % 4, k);
        check("t1_block_id_hold", {bid0[3], bid0[2], bid0[1], bid0[0]}, 64'h0007_0006_0005_0004);
        check("t1_blocks_done_hold", 64'(bdone[0]), 64'd8);

        // Zero-block kernel finishes immediately with no core traffic
        b0   = lg0.size();
        sd   = done_cnt[0];
        sact = act_cnt[0];
        launch(4'hf, 0, c0);
        check("t2_done_pulse", 64'(dn[0]), 64'h1);
        check("t2_blocks_done_cleared", 64'(bdone[0]), 64'h0);
        step(1);
        check("t2_idle", {62'd0, dn[0], bsy[0]}, 64'h0);
        check("t2_done_cycle", 64'(done_at[0]), 64'(c0 + 1));
        check("t2_done_count", 64'(done_cnt[0] - sd), 64'd1);
        check("t2_no_core_activity", 64'(act_cnt[0] - sact), 64'd0);
        check("t2_no_starts", 64'(lg0.size() - b0), 64'd0);

        // Empty mask is refused; sparse mask only uses cores 0 and 2
        mask = 4'h0;
        launch_valid = 1'b1;
        #1;
        check("t3_ready_mask0", {62'd0, rdy[0], rdy[1]}, 64'h0);
        step(2);
        check("t3_not_accepted", 64'(bsy[0]), 64'h0);
        launch_valid = 1'b0;
        b0 = lg0.size();
        launch(4'b0101, 3, c0);
        step(14);
        check("t3_done_pulse", 64'(dn[0]), 64'h1);
        check("t3_blocks_done", 64'(bdone[0]), 64'd3);
        step(1);
        check("t3_log_size", 64'(lg0.size() - b0), 64'd3);
        check_ent("t3_log0", 0, b0,     c0, 3,  0, 0);
        check_ent("t3_log1", 0, b0 + 1, c0, 4,  2, 1);
        check_ent("t3_log2", 0, b0 + 2, c0, 10, 0, 2);

        // Abort after two dispatches
        b0 = lg0.size();
        sd = done_cnt[0];
        sa = ab_cnt[0];
        launch(4'hf, 8, c0);
        step(2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_core_reset_all", 64'(c_reset[0]), 64'h0f);
        check("t4_core_start_off", 64'(c_start[0]), 64'h0);
        check("t4_aborted_pulse", 64'(abd[0]), 64'h1);
        check("t4_no_done", {62'd0, dn[0], bsy[0]}, 64'h0);
        step(1);
        check("t4_ready_after", 64'(rdy[0]), 64'h1);
        check("t4_aborted_low", {62'd0, abd[0], |c_reset[0]}, 64'h0);
        check("t4_abort_count", 64'(ab_cnt[0] - sa), 64'd1);
        check("t4_done_count", 64'(done_cnt[0] - sd), 64'd0);
        check("t4_log_size", 64'(lg0.size() - b0), 64'd1);
        check_ent("t4_log0", 0, b0, c0, 3, 1, 0);

        // Cores 0 and 1 finish on consecutive cycles and are refilled in that order
        b0 = lg0.size();
        b1 = lg1.size();
        launch(4'b0011, 4, c0);
        step(15);
        check("t5a_done_pulse", {62'd0, dn[0], dn[1]}, 64'h3);
        step(1);
        check_ent("t5a_rr0", 0, b0,     c0, 3,  0, 0);
        check_ent("t5a_rr1", 0, b0 + 1, c0, 4,  1, 1);
        check_ent("t5a_rr2", 0, b0 + 2, c0, 10, 0, 2);
        check_ent("t5a_rr3", 0, b0 + 3, c0, 11, 1, 3);
        check_ent("t5a_fp2", 1, b1 + 2, c0, 10, 0, 2);
        check_ent("t5a_fp3", 1, b1 + 3, c0, 11, 1, 3);

        // Park the round-robin pointer on core 0, then present a tie between cores 0 and 1
        launch(4'b0001, 1, c0);
        step(7);
        check("t5b_done_pulse", 64'(dn[0]), 64'h1);
        step(1);
        b0 = lg0.size();
        b1 = lg1.size();
        launch(4'b0011, 2, c0);
        step(8);
        check("t5c_done_pulse", {62'd0, dn[0], dn[1]}, 64'h3);
        step(1);
        check_ent("t5c_rr_first", 0, b0,     c0, 3, 1, 0);
        check_ent("t5c_rr_second", 0, b0 + 1, c0, 4, 0, 1);
        check_ent("t5c_fp_first", 1, b1,     c0, 3, 0, 0);
        check_ent("t5c_fp_second", 1, b1 + 1, c0, 4, 1, 1);

        // Reset in the middle of a kernel
        sd = done_cnt[0];
        sa = ab_cnt[0];
        launch(4'hf, 8, c0);
        step(5);
        reset = 1'b1;
        step(1);
        check("t6_core_reset", 64'(c_reset[0]), 64'h0f);
        check("t6_core_start", 64'(c_start[0]), 64'h0);
        check("t6_block_ids", {bid0[3], bid0[2], bid0[1], bid0[0]}, 64'h0);
        check("t6_flags", {61'd0, bsy[0], dn[0], abd[0]}, 64'h0);
        check("t6_blocks_done", 64'(bdone[0]), 64'h0);
        check("t6_fp_core_reset", 64'(c_reset[1]), 64'h0f);
        reset = 1'b0;
        step(1);
        check("t6_release_core_reset", 64'(c_reset[0]), 64'h0);
        step(8);
        check("t6_idle", {62'd0, bsy[0], |c_start[0]}, 64'h0);
        check("t6_no_done", 64'(done_cnt[0] - sd), 64'd0);
        check("t6_no_aborted", 64'(ab_cnt[0] - sa), 64'd0);

        // Round-robin pointer restarts at core 0 after reset
        b0 = lg0.size();
        launch(4'b0011, 2, c0);
        step(8);
        check("t7_done_pulse", 64'(dn[0]), 64'h1);
        step(1);
        check_ent("t7_rr_first", 0, b0,     c0, 3, 0, 0);
        check_ent("t7_rr_second", 0, b0 + 1, c0, 4, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
